cluster_mem_responder: RTL
==========================

Name: cluster_mem_responder

Overview:
- Memory-side responder for the hart cluster's single shared request port: it receives the arbitrated instruction/data requests and answers them.
- Accepts one fetch, load or store at a time, holds busy for a fixed latency, then returns instruction lines or aligned load data.
- Backed by an internal word-addressed RAM and used as the DRAM/BRAM stand-in for cluster bring-up and simulation.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of RAM word 0.
- DEPTH_WORDS, 4096, RAM size in 32-bit words; power of two.
- LATENCY, 2, cycles busy stays high per request; legal range 1..15.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- w_iaddr  in  32  fetch byte address.
- w_daddr  in  32  load/store byte address.
- w_data_wdata  in  32  store data, right-justified.
- w_data_ctrl  in  3  size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- w_iscode  in  1  fetch request.
- w_isread  in  1  load request.
- w_iswrite  in  1  store request.
- w_busy  out  1  request in flight.
- w_insn_data  out  128  16-byte line containing w_iaddr, word 0 in [31:0].
- w_data_data  out  128  load result, extended, in [31:0]; [127:32] zero.
- w_fault  out  1  last request was out-of-range or misaligned.

Behaviour:
- Reset: all outputs 0; state IDLE. RAM contents are not cleared. RST asserted mid-request aborts it: a pending store is not written, and the FSM returns to IDLE.
- FSM states:
  - IDLE: accept when any of w_iscode/w_isread/w_iswrite is high at a CLK edge. Latch the kind, address, ctrl and wdata. Set w_busy=1 and the counter to LATENCY-1. Go to WAIT.
  - WAIT: decrement the counter each cycle; at 0 go to RESP.
  - RESP (1 cycle): perform the access. Drive w_insn_data (fetch) or w_data_data (load), set w_fault, clear w_busy. Return to IDLE.
- Latency: w_busy is high for exactly LATENCY cycles, starting the cycle after acceptance. Results are valid from the edge where w_busy falls and are held until the next acceptance.
- Inputs are ignored while w_busy=1.
- Back-to-back requests: the requester may hold a request high; it is re-accepted on the first edge with w_busy=0. The requester must drop request strobes in the cycle w_busy falls if no new request is wanted.
- Simultaneous strobes: priority is iscode > iswrite > isread. Only the winner is serviced; the loser must be re-presented.
- Address decode:
  - index = (addr - ADDR_BASE) >> 2.
  - In range when ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS.
  - Out of range: w_fault=1, no write, read data 0.
- Fetch: line index = index with [1:0] cleared; returns 4 consecutive words.
- Misalignment:
  - Halfword access with addr[0]=1, or word access with addr[1:0]≠0, gives w_fault=1, no write, data 0.
  - Fetch requires only addr[1:0]=0.
- Store: byte enables from ctrl[1:0] and addr[1:0]; data is lane-replicated; read-modify-write of a single word in the RESP cycle.
- Load: select byte/half lane by addr[1:0]. Sign-extend for ctrl[2]=0, zero-extend for ctrl[2]=1.
- w_fault is updated on every completed request.

Decomposition:
- Shared package: the w_data_ctrl encodings (LB/LH/LW/LBU/LHU), FSM state encodings (IDLE/WAIT/RESP), and the default ADDR_BASE.
- One sub-module, mem_lane_align, which is purely combinational. Store path: ctrl + addr[1:0] + wdata → byte mask and lane-shifted data. Load path: ctrl + addr[1:0] + word → extended result. Misalignment flag.

Test Plan:
- Reset mid-request: assert RST during WAIT of a store SW 0x8000_0010 ← 0xDEADBEEF → w_busy=0 immediately; a later LW from 0x8000_0010 shows the old value.
- Word store then load: SW 0x8000_0020 ← 0x12345678, then LW 0x8000_0020 → w_data_data[31:0]=0x12345678, w_fault=0, w_busy high exactly 2 cycles each (LATENCY=2).
- Sub-word ops on word 0x8000_0020=0x12345678:
  - SB 0x8000_0021 ← 0xAB → word = 0x1234AB78.
  - LB 0x8000_0021 → 0xFFFFFFAB.
  - LBU → 0x000000AB.
  - LH 0x8000_0022 → 0x00001234.
- Fetch line: preload words 0..3 = 1,2,3,4; fetch 0x8000_0008 → w_insn_data = {32'd4, 32'd3, 32'd2, 32'd1}.
- Faults:
  - LW 0x8000_0002 → w_fault=1, data 0.
  - SW 0x7FFF_FFFC → w_fault=1, RAM unchanged.
  - LH 0x8000_0001 → w_fault=1.
- Priority and hold: w_iscode+w_isread together → fetch serviced first; isread held → second acceptance on the first edge with w_busy=0, load result correct.

Source files
------------

// File: rtl/cluster_mem_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cluster_mem_responder_pkg                                          |
// | Shared encodings for the cluster memory responder.                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package cluster_mem_responder_pkg;

   localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h8000_0000;

   localparam logic [2:0] CTRL_LB  = 3'b000;
   localparam logic [2:0] CTRL_LH  = 3'b001;
   localparam logic [2:0] CTRL_LW  = 3'b010;
   localparam logic [2:0] CTRL_LBU = 3'b100;
   localparam logic [2:0] CTRL_LHU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      REQ_FETCH = 2'd0,
      REQ_LOAD  = 2'd1,
      REQ_STORE = 2'd2
   } req_kind_t;

endpackage
`default_nettype wire

// File: rtl/cluster_mem_responder_mem_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_lane_align                                                     |
// | Byte-lane steering for stores, lane extraction/extension for loads.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_lane_align
   import cluster_mem_responder_pkg::*;
(
   input  logic [2:0]  ctrl,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_mask,
   output logic [31:0] lane_data,
   output logic [31:0] load_data,
   output logic        misaligned
);

   logic        is_byte;
   logic        is_half;
   logic        sext;
   logic [31:0] shifted;

   always_comb begin
      is_byte = 1'b0;
      is_half = 1'b0;
      case (ctrl)
         CTRL_LB, CTRL_LBU: is_byte = 1'b1;
         CTRL_LH, CTRL_LHU: is_half = 1'b1;
         default:           ;
      endcase
   end

   // Undefined size codes fall through to full-word behaviour.
   always_comb begin
      sext       = ~ctrl[2];
      shifted    = rword >> {addr_lo, 3'b000};
      byte_mask  = 4'b1111;
      lane_data  = wdata;
      load_data  = rword;
      misaligned = (addr_lo != 2'b00);
      if (is_byte) begin
         byte_mask  = 4'b0001 << addr_lo;
         lane_data  = {4{wdata[7:0]}};
         load_data  = {{24{sext & shifted[7]}}, shifted[7:0]};
         misaligned = 1'b0;
      end else if (is_half) begin
         byte_mask  = 4'b0011 << addr_lo;
         lane_data  = {2{wdata[15:0]}};
         load_data  = {{16{sext & shifted[15]}}, shifted[15:0]};
         misaligned = addr_lo[0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/cluster_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cluster_mem_responder                                              |
// | Fixed-latency RAM responder for the cluster's shared request port. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cluster_mem_responder
   import cluster_mem_responder_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
   parameter int          DEPTH_WORDS = 4096,
   parameter int          LATENCY     = 2
)
(
   input  logic         CLK,
   input  logic         RST,
   input  logic [31:0]  w_iaddr,
   input  logic [31:0]  w_daddr,
   input  logic [31:0]  w_data_wdata,
   input  logic [2:0]   w_data_ctrl,
   input  logic         w_iscode,
   input  logic         w_isread,
   input  logic         w_iswrite,
   output logic         w_busy,
   output logic [127:0] w_insn_data,
   output logic [127:0] w_data_data,
   output logic         w_fault
);

   localparam int          IDX_W       = $clog2(DEPTH_WORDS);
   localparam logic [32:0] RANGE_BYTES = 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [3:0]  CNT_INIT    = 4'(LATENCY - 1);

   logic [31:0]    mem [DEPTH_WORDS];

   state_t         state, state_nx;
   req_kind_t      kind, kind_nx;
   logic [3:0]     cnt, cnt_nx;
   logic [31:0]    addr, addr_nx;
   logic [31:0]    wdata, wdata_nx;
   logic [2:0]     ctrl, ctrl_nx;
   logic [127:0]   insn_nx, data_nx;
   logic           fault_nx;
   logic           wr_en;

   logic [31:0]    offset;
   logic           in_range;
   logic [IDX_W-1:0] idx;
   logic [31:0]    word;
   logic [127:0]   line;
   logic [3:0]     byte_mask;
   logic [31:0]    bit_mask;
   logic [31:0]    lane_data;
   logic [31:0]    load_data;
   logic [31:0]    merged;
   logic           misaligned;

   // Subtracting first lets addresses below the base wrap to large offsets.
   assign offset   = addr - ADDR_BASE;
   assign in_range = {1'b0, offset} < RANGE_BYTES;
   assign idx      = offset[IDX_W+1:2];
   assign word     = mem[idx];
   assign line     = {mem[{idx[IDX_W-1:2], 2'd3}], mem[{idx[IDX_W-1:2], 2'd2}],
                      mem[{idx[IDX_W-1:2], 2'd1}], mem[{idx[IDX_W-1:2], 2'd0}]};
   assign bit_mask = {{8{byte_mask[3]}}, {8{byte_mask[2]}},
                      {8{byte_mask[1]}}, {8{byte_mask[0]}}};
   assign merged   = (word & ~bit_mask) | (lane_data & bit_mask);
   assign w_busy   = (state != ST_IDLE);

   mem_lane_align u_align (
      .ctrl       (ctrl),
      .addr_lo    (addr[1:0]),
      .wdata      (wdata),
      .rword      (word),
      .byte_mask  (byte_mask),
      .lane_data  (lane_data),
      .load_data  (load_data),
      .misaligned (misaligned)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= ST_IDLE;
         kind        <= REQ_FETCH;
         cnt         <= 4'd0;
         addr        <= 32'd0;
         wdata       <= 32'd0;
         ctrl        <= 3'd0;
         w_insn_data <= 128'd0;
         w_data_data <= 128'd0;
         w_fault     <= 1'b0;
      end else begin
         state       <= state_nx;
         kind        <= kind_nx;
         cnt         <= cnt_nx;
         addr        <= addr_nx;
         wdata       <= wdata_nx;
         ctrl        <= ctrl_nx;
         w_insn_data <= insn_nx;
         w_data_data <= data_nx;
         w_fault     <= fault_nx;
      end
   end

   // RESP is the last busy cycle; results land on the edge that leaves it.
   always_comb begin
      state_nx = state;
      kind_nx  = kind;
      cnt_nx   = cnt;
      addr_nx  = addr;
      wdata_nx = wdata;
      ctrl_nx  = ctrl;
      insn_nx  = w_insn_data;
      data_nx  = w_data_data;
      fault_nx = w_fault;
      wr_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (w_iscode || w_isread || w_iswrite) begin
               state_nx = (LATENCY == 1) ? ST_RESP : ST_WAIT;
               cnt_nx   = CNT_INIT;
               ctrl_nx  = w_data_ctrl;
               wdata_nx = w_data_wdata;
               if (w_iscode) begin
                  kind_nx = REQ_FETCH;
                  addr_nx = w_iaddr;
               end else if (w_iswrite) begin
                  kind_nx = REQ_STORE;
                  addr_nx = w_daddr;
               end else begin
                  kind_nx = REQ_LOAD;
                  addr_nx = w_daddr;
               end
            end
         end
         ST_WAIT: begin
            cnt_nx = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nx = ST_RESP;
            end
         end
         ST_RESP: begin
            state_nx = ST_IDLE;
            case (kind)
               REQ_FETCH: begin
                  fault_nx = !in_range || (addr[1:0] != 2'b00);
                  insn_nx  = fault_nx ? 128'd0 : line;
               end
               REQ_LOAD: begin
                  fault_nx = !in_range || misaligned;
                  data_nx  = fault_nx ? 128'd0 : {96'd0, load_data};
               end
               default: begin
                  fault_nx = !in_range || misaligned;
                  wr_en    = !fault_nx;
               end
            endcase
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Reset drops the FSM out of RESP asynchronously, so an aborted store never writes.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[idx] <= merged;
      end
   end

endmodule
`default_nettype wire
